// File: rtl/conv_post_quant_writer.sv
// -----------------------------------------------------------------------------
// conv_post_quant_writer
//
// Turns each registered 32-bit convolution sum from the final adder-tree stage
// into one unsigned feature-map pixel and its write address. The path is
// bias add with round-half-up, ReLU, right shift, and unsigned saturation.
// A small frame controller numbers the pixels row-major and raises a one-cycle
// done pulse once the last pixel of the frame has been written.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active high
//   frame_start  1-cycle pulse, arms a new frame (honoured in IDLE only)
//   bias         signed bias, held stable for the frame
//   in_data      signed 32-bit sum from the adder stage
//   in_valid     in_data qualifier
//   out_data     quantised pixel, OUT_W bits unsigned
//   out_addr     pixel address, row*OUT_COLS+col
//   out_valid    write enable for out_data/out_addr
//   busy         high while a frame is running or draining
//   done         1-cycle pulse after the last pixel of the frame
// -----------------------------------------------------------------------------
module conv_post_quant_writer #(
    parameter int OUT_ROWS = 18,
    parameter int OUT_COLS = 22,
    parameter int SHIFT    = 8,
    parameter int OUT_W    = 8,
    parameter int ADDR_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [31:0]       bias,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int                TOTAL     = OUT_ROWS * OUT_COLS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(OUT_COLS);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(OUT_COLS - 1);
    // Half an output LSB, so the later truncating shift rounds half-up.
    localparam logic [33:0]       ROUND     = 34'd1 << (SHIFT - 1);
    localparam logic [33:0]       SAT_MAX   = (34'd1 << OUT_W) - 34'd1;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   row;
    logic [ADDR_W-1:0]   col;
    logic [ADDR_W-1:0]   cur_addr;
    logic                accept;
    logic                last_accept;

    logic                s1_valid;
    logic [33:0]         s1_sum;
    logic [ADDR_W-1:0]   s1_addr;
    logic [33:0]         s1_shifted;
    logic [OUT_W-1:0]    s1_quant;

    assign cur_addr    = row * COLS_A + col;
    assign accept      = (state == RUN) && in_valid;
    assign last_accept = accept && (cur_addr == LAST_ADDR);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case,
        // otherwise a path that skips an assignment would infer a latch.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_accept) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Leave once the final pixel is actually on the write port.
                if (out_valid && (out_addr == LAST_ADDR)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------ pixel counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if ((state == IDLE) && frame_start) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // --------------------------------------------- stage 1: bias + rounding
    // 34 bits hold the sum of two sign-extended 32-bit values plus ROUND
    // without overflow, so the sign bit is always trustworthy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum  <= {{2{in_data[31]}}, in_data}
                         + {{2{bias[31]}}, bias}
                         + ROUND;
                s1_addr <= cur_addr;
            end
        end
    end

    // ------------------------------------------ stage 2: ReLU + saturation
    // Negative sums are zeroed before the shift, so a logical shift suffices.
    assign s1_shifted = s1_sum >> SHIFT;

    always_comb begin
        s1_quant = '0;
        if (!s1_sum[33]) begin
            if (s1_shifted > SAT_MAX) s1_quant = SAT_MAX[OUT_W-1:0];
            else                      s1_quant = s1_shifted[OUT_W-1:0];
        end
    end

    // Data and address only load with a valid sample, holding otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_quant;
                out_addr <= s1_addr;
            end
        end
    end

endmodule

// File: tb/tb_conv_post_quant_writer.sv
// -----------------------------------------------------------------------------
// tb_conv_post_quant_writer
//
// Drives conv_post_quant_writer one clock at a time. A reference model built
// from frame-level bookkeeping (pixel count, expected-output queue keyed by
// edge number, expected done edge) predicts every output after every edge.
// A table of fixed vectors with hand-computed pixels covers the quantiser
// corners; random data, gaps, stray frame_start pulses and a mid-frame reset
// cover the frame controller.
// -----------------------------------------------------------------------------
module tb_conv_post_quant_writer;

    localparam int OUT_ROWS = 18;
    localparam int OUT_COLS = 22;
    localparam int SHIFT    = 8;
    localparam int OUT_W    = 8;
    localparam int ADDR_W   = 9;
    localparam int TOTAL    = OUT_ROWS * OUT_COLS;
    localparam int OBS_N    = 8192;

    logic              clk;
    logic              rst;
    logic              frame_start;
    logic [31:0]       bias;
    logic [31:0]       in_data;
    logic              in_valid;
    logic [OUT_W-1:0]  out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              busy;
    logic              done;

    conv_post_quant_writer #(
        .OUT_ROWS (OUT_ROWS),
        .OUT_COLS (OUT_COLS),
        .SHIFT    (SHIFT),
        .OUT_W    (OUT_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .bias        (bias),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------- bookkeeping
    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    typedef struct {
        int due;
        int addr;
        int data;
    } exp_t;

    exp_t exp_q[$];
    bit   run;
    int   pix;
    int   done_edge;
    int   last_data;
    int   last_addr;
    int   done_count;

    logic              obs_valid [OBS_N];
    logic [OUT_W-1:0]  obs_data  [OBS_N];
    logic [ADDR_W-1:0] obs_addr  [OBS_N];

    typedef struct {
        logic [31:0] d;
        logic [31:0] b;
        int          exp;
    } vec_t;

    vec_t vecs [7];
    int   acc  [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Pixel value straight from the arithmetic definition, in wide integers.
    function automatic int ref_quant(input logic [31:0] d, input logic [31:0] b);
        longint s;
        longint maxv;
        s    = longint'($signed(d)) + longint'($signed(b)) + (longint'(1) << (SHIFT - 1));
        maxv = (longint'(1) << OUT_W) - 1;
        if (s < 0) return 0;
        s = s / (longint'(1) << SHIFT);
        if (s > maxv) return int'(maxv);
        return int'(s);
    endfunction

    // One clock: drive inputs, let the edge happen, update model, compare.
    task automatic step(input bit r, input bit fs, input bit iv,
                        input logic [31:0] d, input logic [31:0] b,
                        output int acc_edge);
        bit   idle;
        bit   exp_v;
        bit   exp_busy;
        bit   exp_done;
        exp_t e;
        rst         = r;
        frame_start = fs;
        in_valid    = iv;
        in_data     = d;
        bias        = b;
        acc_edge    = -1;
        @(posedge clk);
        edge_n++;
        if (r) begin
            run       = 1'b0;
            done_edge = -1;
            exp_q.delete();
            last_data = 0;
            last_addr = 0;
        end else begin
            // Idle once the frame finished and the done cycle has elapsed.
            idle = !run && ((done_edge < 0) || (edge_n > done_edge + 1));
            if (idle && fs) begin
                run = 1'b1;
                pix = 0;
            end else if (run && iv) begin
                exp_q.push_back('{edge_n + 1, pix, ref_quant(d, b)});
                acc_edge = edge_n;
                pix++;
                if (pix == TOTAL) begin
                    run       = 1'b0;
                    done_edge = edge_n + 2;
                end
            end
        end
        exp_v = 1'b0;
        if ((exp_q.size() > 0) && (exp_q[0].due == edge_n)) begin
            e         = exp_q.pop_front();
            last_data = e.data;
            last_addr = e.addr;
            exp_v     = 1'b1;
        end
        exp_busy = run || ((done_edge >= 0) && (edge_n < done_edge));
        exp_done = (edge_n == done_edge);
        #1;
        check("out_valid", 64'(out_valid), 64'(exp_v));
        check("out_data",  64'(out_data),  64'(last_data));
        check("out_addr",  64'(out_addr),  64'(last_addr));
        check("busy",      64'(busy),      64'(exp_busy));
        check("done",      64'(done),      64'(exp_done));
        if (done === 1'b1) done_count++;
        if (edge_n < OBS_N) begin
            obs_valid[edge_n] = out_valid;
            obs_data[edge_n]  = out_data;
            obs_addr[edge_n]  = out_addr;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_data();
        return 32'($urandom_range(0, 200000)) - 32'd100000;
    endfunction

    // -------------------------------------------------------------- stimulus
    initial begin
        int          a;
        logic [31:0] fb;

        vecs[0] = '{32'd1000,        32'd24,          4};
        vecs[1] = '{-32'sd5000,      32'd0,           0};
        vecs[2] = '{-32'sd128,       32'd0,           0};
        vecs[3] = '{32'd127,         32'd0,           0};
        vecs[4] = '{32'd128,         32'd0,           1};
        vecs[5] = '{32'd100000,      32'd0,           255};
        vecs[6] = '{32'h7FFF_FFFF,   32'h7FFF_FFFF,   255};

        run = 1'b0; pix = 0; done_edge = -1; last_data = 0; last_addr = 0;
        done_count = 0;

        // Reset: all outputs zero.
        step(1, 0, 0, 0, 0, a);
        step(1, 1, 1, 32'd5, 0, a);

        // Valid while IDLE is ignored.
        repeat (3) step(0, 0, 1, rand_data(), 0, a);

        // frame_start with in_valid arms RUN but drops that sample.
        step(0, 1, 1, 32'd999, 0, a);

        // Table vectors as the first pixels, back to back.
        for (int i = 0; i < 7; i++) step(0, 0, 1, vecs[i].d, vecs[i].b, acc[i]);

        // Rest of frame 1: gapped 1-on/2-off for a while, then back to back,
        // with stray frame_start pulses that must be ignored.
        fb = 32'($urandom_range(0, 2000)) - 32'd1000;
        for (int k = 0; (k < 2000) && run; k++) begin
            step(0, ($urandom_range(0, 15) == 0), 1, rand_data(), fb, a);
            if (pix < 150) begin
                step(0, 0, 0, rand_data(), fb, a);
                step(0, 0, 0, rand_data(), fb, a);
            end
        end
        repeat (6) step(0, ($urandom_range(0, 1) == 0), 0, 0, fb, a);

        for (int i = 0; i < 7; i++) begin
            check($sformatf("tbl%0d_valid", i), 64'(obs_valid[acc[i] + 1]), 64'd1);
            check($sformatf("tbl%0d_data", i),  64'(obs_data[acc[i] + 1]),  64'(vecs[i].exp));
            check($sformatf("tbl%0d_addr", i),  64'(obs_addr[acc[i] + 1]),  64'(i));
        end
        check("frame1_done_pulses", 64'(done_count), 64'd1);

        // Frame 2: random gaps, reset once pixel 100 is accepted.
        step(0, 1, 0, 0, 0, a);
        fb = 32'($urandom_range(0, 2000)) - 32'd1000;
        for (int k = 0; (k < 2000) && run && (pix < 101); k++) begin
            step(0, 0, ($urandom_range(0, 2) != 0), rand_data(), fb, a);
        end
        step(1, 0, 1, rand_data(), fb, a);
        repeat (5) step(0, 0, 1, rand_data(), fb, a);
        check("reset_no_done", 64'(done_count), 64'd1);

        // Frame 3: restarts at address 0, back to back to the end.
        step(0, 1, 0, 0, 0, a);
        fb = 32'($urandom_range(0, 400));
        for (int k = 0; (k < 2000) && run; k++) begin
            step(0, ($urandom_range(0, 20) == 0), 1, rand_data(), fb, a);
        end
        repeat (6) step(0, 0, 1, rand_data(), fb, a);
        check("frame3_done_pulses", 64'(done_count), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
